// File: rtl/monitor_wl_rx.sv
// Monitor write-line receiver: debounced single-strobe capture of mwl into a 4-deep FWFT FIFO.
// Optional feature macro: MONITOR_WL_RX_TIMESTAMP_EN adds a per-word 16-bit cycle timestamp (out_ts).
module monitor_wl_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mwl,
    input  logic [5:0]  mw_str,
    input  logic [5:0]  src_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_src,
    output logic        ovf,
    input  logic        ovf_clr,
`ifdef MONITOR_WL_RX_TIMESTAMP_EN
    output logic [15:0] out_ts,
`endif
    output logic [7:0]  drop_cnt
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SRC_N  = 6;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DROP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_k;
    logic [IDX_W-1:0]    w_k_nxt;

    logic [SRC_N-1:0]    w_s;
    logic                w_any;
    logic                w_multi;
    logic [IDX_W-1:0]    w_idx;
    logic                w_capture;
    logic                w_multi_drop;

    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [IDX_W-1:0]    r_src  [DEPTH];
    logic [CNT_W-1:0]    r_cnt;
    logic                r_valid;
    logic                r_ovf;
    logic [DROP_W-1:0]   r_drop;

    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [CNT_W-1:0]    w_wr_idx;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // Effective strobes, multi-bit detect and index encode
    always_comb begin
        w_s     = mw_str & src_en;
        w_any   = |w_s;
        w_multi = |(w_s & (w_s - SRC_N'(1)));
        w_idx   = '0;
        for (int i = 0; i < int'(SRC_N); i++) begin
            if (w_s[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // A strobe must be seen alone for two consecutive cycles to capture
    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_capture    = 1'b0;
        w_multi_drop = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_multi) begin
                    w_state_nxt  = ST_HOLD;
                    w_multi_drop = 1'b1;
                end else if (w_any) begin
                    w_state_nxt = ST_ARM;
                    w_k_nxt     = w_idx;
                end
            end
            ST_ARM: begin
                if (w_s == (SRC_N'(1) << r_k)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!w_any) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_full    = (r_cnt == CNT_W'(DEPTH));
        w_pop     = r_valid & out_ready;
        w_push    = w_capture & (~w_full | w_pop);
        w_drop    = (w_capture & w_full & ~w_pop) | w_multi_drop;
        w_wr_idx  = r_cnt - CNT_W'(w_pop);
        w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_data[i] <= '0;
                r_src[i]  <= '0;
            end
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (w_pop && (i < int'(DEPTH) - 1)) begin
                    r_data[i] <= r_data[i+1];
                    r_src[i]  <= r_src[i+1];
                end
                if (w_push && (w_wr_idx == CNT_W'(i))) begin
                    r_data[i] <= mwl;
                    r_src[i]  <= r_k;
                end
            end
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
        end
    end

    // Sticky error flag and saturating drop counter; a new drop beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr) begin
                r_drop <= DROP_W'(1);
            end else if (r_drop != '1) begin
                r_drop <= r_drop + DROP_W'(1);
            end
        end else if (ovf_clr) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end
    end

`ifdef MONITOR_WL_RX_TIMESTAMP_EN
    logic [DATA_W-1:0] r_ts;
    logic [DATA_W-1:0] r_tsq [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_tsq[i] <= '0;
            end
        end else begin
            r_ts <= r_ts + DATA_W'(1);
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (w_pop && (i < int'(DEPTH) - 1)) begin
                    r_tsq[i] <= r_tsq[i+1];
                end
                if (w_push && (w_wr_idx == CNT_W'(i))) begin
                    r_tsq[i] <= r_ts;
                end
            end
        end
    end

    assign out_ts = r_tsq[0];
`endif

    assign out_valid = r_valid;
    assign out_data  = r_data[0];
    assign out_src   = r_src[0];
    assign ovf       = r_ovf;
    assign drop_cnt  = r_drop;

endmodule

// File: doc/monitor_wl_rx.md
MONITOR_WL_RX -- requirements
Module: monitor_wl_rx

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk drives all state; rst (high) is sampled only on the rising edge of clk.
REQ-002 SHALL provide: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL provide: rst  input  1  synchronous active-high reset.
REQ-004 SHALL provide: mwl  input  16  monitor write lines, active-high; mwl[0]=MWL01 ... mwl[15]=MWL16.
REQ-005 SHALL provide: mw_str  input  6  source strobes: bit0 MWG, bit1 MWAG, bit2 MWLG, bit3 MWQG, bit4 MWZG, bit5 MWBG.
REQ-006 SHALL provide: src_en  input  6  per-strobe enable mask; disabled strobes are treated as low.
REQ-007 SHALL provide: out_valid  output  1  FIFO head holds a captured word.
REQ-008 SHALL provide: out_ready  input  1  consumer accepts the head word.
REQ-009 SHALL provide: out_data  output  16  captured mwl value.
REQ-010 SHALL provide: out_src  output  3  index 0-5 of the capturing strobe.
REQ-011 SHALL provide: ovf  output  1  sticky overflow/error flag.
REQ-012 SHALL provide: ovf_clr  input  1  clears ovf and drop_cnt.
REQ-013 SHALL provide: drop_cnt  output  8  saturating count of discarded events.

Function
REQ-014 SHALL form the effective strobe vector s = mw_str & src_en each cycle.
REQ-015 SHALL implement FSM IDLE/ARM/HOLD; IDLE: s one-hot -> ARM, latch index k; s with 2+ bits set -> HOLD, drop_cnt+1, ovf=1; s=0 -> stay.
REQ-016 SHALL, in ARM: if s equals exactly bit k, capture {mwl,k} this cycle and go to HOLD; otherwise go to IDLE with no capture (one-cycle glitch rejected, nothing counted).
REQ-017 SHALL, in HOLD, remain until s=0, then go to IDLE; one capture per strobe pulse regardless of pulse length.
REQ-018 SHALL buffer captures in a 4-entry first-word-fall-through FIFO; out_valid=1 iff non-empty; pop on out_valid&out_ready.
REQ-019 SHALL present a word captured on cycle N at the outputs on cycle N+1 when the FIFO was empty.
REQ-020 SHALL, on capture with FIFO full and no pop in the same cycle, discard the word, set ovf, increment drop_cnt.
REQ-021 SHALL, on capture with FIFO full and a pop in the same cycle, accept the word with no overflow.
REQ-022 SHALL saturate drop_cnt at 255.
REQ-023 SHALL give set priority over ovf_clr when both occur in one cycle (ovf=1, drop_cnt=1).
REQ-024 SHALL keep out_data/out_src stable while out_valid=1 and out_ready=0.

Reset
REQ-025 SHALL, with rst high at a clock edge, force FSM=IDLE, FIFO empty, out_valid=0, out_data=0, out_src=0, ovf=0, drop_cnt=0 and timestamp=0, and discard any in-progress capture.
REQ-026 SHALL ignore mw_str, out_ready and ovf_clr during reset; a strobe held high across reset release is treated as a new pulse from IDLE.

Configuration
REQ-027 SHALL honour macro MONITOR_WL_RX_TIMESTAMP_EN: when defined, a free-running 16-bit cycle counter (wraps 65535->0) is stored with each capture and presented on output out_ts (16 bits) alongside out_data.
REQ-028 SHALL, without MONITOR_WL_RX_TIMESTAMP_EN, omit the counter, the out_ts port and the timestamp FIFO storage; all other behaviour is identical.

Verification
REQ-029 SHALL cover: mwl=16'o52525 with MWAG high 3 cycles, out_ready=1 -> exactly one word, out_data=16'o52525, out_src=1, out_valid one cycle after the 2nd strobe cycle.
REQ-030 SHALL cover: MWG pulse 1 cycle wide -> no capture, drop_cnt=0, ovf=0.
REQ-031 SHALL cover: MWG and MWZG rising together -> no capture, ovf=1, drop_cnt=1; ovf_clr -> both 0.
REQ-032 SHALL cover: out_ready=0, 6 pulses on MWLG -> 4 words buffered in order, ovf=1, drop_cnt=2; drain gives the first 4 values.
REQ-033 SHALL cover: FIFO full, capture coincident with pop -> no overflow, 4 words remain, newest at tail.
REQ-034 SHALL cover (macro defined): captures 10 cycles apart after reset -> out_ts difference exactly 10; rst mid-ARM -> no word emitted.
